// File: rtl/ccip_c1_tx_arbiter.sv
// CCI-P channel-1 TX arbiter: packet-granular round-robin over NUM_REQ requesters with a registered TX beat.
// Optional feature CCIP_C1_ARB_MDATA_TAG_EN tags mdata with the requester index and steers responses back.
module ccip_c1_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int HDR_W   = 80
) (
  input  logic                     pClk,
  input  logic                     SoftReset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*HDR_W-1:0] req_hdr,
  input  logic [NUM_REQ*512-1:0]   req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  input  logic                     c1TxAlmFull,
  output logic                     c1Tx_valid,
  output logic [HDR_W-1:0]         c1Tx_hdr,
  output logic [511:0]             c1Tx_data,
  output logic                     busy,
  output logic                     err_proto
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
  ,
  input  logic                     c1Rx_rspValid,
  input  logic [15:0]              c1Rx_mdata,
  output logic [NUM_REQ-1:0]       rsp_valid
`endif
);

  localparam int SOP_B = 71;
  localparam int LEN_B = 68;
  localparam int TYP_B = 64;

  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [3:0] REQ_WRLINE_M = 4'h1;
  localparam logic [3:0] REQ_WRPUSH_I = 4'h2;

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [1:0]         r_beats_left, w_beats_nxt;
  logic [3:0]         r_type, w_type_nxt;
  logic               r_err;
  logic               r_tx_valid;
  logic [HDR_W-1:0]   r_tx_hdr;
  logic [511:0]       r_tx_data;

  logic [NUM_REQ-1:0] w_elig, w_ack;
  logic               w_found, w_accept, w_err_set;
  logic [IDX_W-1:0]   w_win, w_sel;
  logic [HDR_W-1:0]   w_hdr, w_hdr_fwd;
  logic [511:0]       w_data;
  logic               w_sop, w_is_wr, w_len_err;
  logic [1:0]         w_cl_len, w_len_m1;
  logic [3:0]         w_req_type;

  // a and b are both below NUM_REQ, so one conditional subtract wraps correctly
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
    logic [IDX_W+1:0] s;
    s = {2'b00, a} + (IDX_W+2)'(b);
    if (s >= (IDX_W+2)'(NUM_REQ)) s = s - (IDX_W+2)'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction

  assign w_elig = req_valid & {NUM_REQ{~c1TxAlmFull}};

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_elig[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_sel      = (r_state == ST_BURST) ? r_owner : w_win;
  assign w_hdr      = req_hdr[w_sel*HDR_W +: HDR_W];
  assign w_data     = req_data[w_sel*512 +: 512];
  assign w_sop      = w_hdr[SOP_B];
  assign w_cl_len   = w_hdr[LEN_B +: 2];
  assign w_req_type = w_hdr[TYP_B +: 4];
  assign w_is_wr    = (w_req_type == REQ_WRLINE_I) || (w_req_type == REQ_WRLINE_M) ||
                      (w_req_type == REQ_WRPUSH_I);

  // Remaining beats after the head; a write without sop is a lone protocol-error beat
  always_comb begin
    w_len_m1  = 2'd0;
    w_len_err = 1'b0;
    if (w_is_wr) begin
      if (!w_sop) w_len_err = 1'b1;
      else begin
        case (w_cl_len)
          2'b01:   w_len_m1 = 2'd1;
          2'b11:   w_len_m1 = 2'd3;
          2'b10:   w_len_err = 1'b1;
          default: w_len_m1 = 2'd0;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_beats_nxt = r_beats_left;
    w_type_nxt  = r_type;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_accept   = 1'b1;
          w_err_set  = w_len_err;
          w_type_nxt = w_req_type;
          if (w_len_m1 != 2'd0) begin
            w_beats_nxt = w_len_m1;
            w_owner_nxt = w_win;
            w_state_nxt = ST_BURST;
          end else begin
            w_ptr_nxt = wrap_add(w_win, 1);
          end
        end
      end
      ST_BURST: begin
        if (req_valid[r_owner]) begin
          w_accept    = 1'b1;
          w_err_set   = w_sop || (w_req_type != r_type);
          w_beats_nxt = r_beats_left - 2'd1;
          if (r_beats_left == 2'd1) begin
            w_state_nxt = ST_ARB;
            w_ptr_nxt   = wrap_add(r_owner, 1);
          end
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
    if (!SoftReset_n) w_accept = 1'b0;
  end

  always_comb begin
    w_ack        = '0;
    w_ack[w_sel] = w_accept;
  end

  always_comb begin
    w_hdr_fwd = w_hdr;
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    w_hdr_fwd[15 -: IDX_W] = w_sel;
`endif
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      r_state      <= ST_ARB;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_beats_left <= '0;
      r_type       <= '0;
      r_err        <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_hdr     <= '0;
      r_tx_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_beats_left <= w_beats_nxt;
      r_type       <= w_type_nxt;
      r_tx_valid   <= w_accept;
      if (w_accept) begin
        r_tx_hdr  <= w_hdr_fwd;
        r_tx_data <= w_data;
      end
      if (w_accept && w_err_set) r_err <= 1'b1;
    end
  end

`ifdef CCIP_C1_ARB_MDATA_TAG_EN
  logic [NUM_REQ-1:0] r_rsp;
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) r_rsp <= '0;
    else begin
      r_rsp <= '0;
      if (c1Rx_rspValid) r_rsp[c1Rx_mdata[15 -: IDX_W]] <= 1'b1;
    end
  end
  assign rsp_valid = r_rsp;
`endif

  assign req_ack    = w_ack;
  assign c1Tx_valid = r_tx_valid;
  assign c1Tx_hdr   = r_tx_hdr;
  assign c1Tx_data  = r_tx_data;
  assign busy       = (r_state == ST_BURST);
  assign err_proto  = r_err;

endmodule

// File: tb/tb_ccip_c1_tx_arbiter.sv
// Vector-table bench for ccip_c1_tx_arbiter (NUM_REQ=4); one vector per cycle, plus mdata-tag sequence when enabled.
module tb_ccip_c1_tx_arbiter;
  localparam int N  = 4;
  localparam int HW = 80;

  localparam logic [7:0] W1 = 8'h80;  // {sop, -, cl_len, req_type}
  localparam logic [7:0] W2 = 8'h90;
  localparam logic [7:0] W4 = 8'hB0;
  localparam logic [7:0] WR = 8'hA0;
  localparam logic [7:0] WC = 8'h00;
  localparam logic [7:0] FN = 8'h04;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*HW-1:0]   req_hdr;
  logic [N*512-1:0]  req_data;
  logic [N-1:0]      req_ack;
  logic              almf;
  logic              tx_valid;
  logic [HW-1:0]     tx_hdr;
  logic [511:0]      tx_data;
  logic              busy, err;
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
  logic              rx_v;
  logic [15:0]       rx_md;
  logic [N-1:0]      rsp_valid;
`endif

  always #5 clk = ~clk;

  ccip_c1_tx_arbiter #(.NUM_REQ(N), .HDR_W(HW)) dut (
    .pClk(clk), .SoftReset_n(rst_n), .req_valid(req_valid), .req_hdr(req_hdr),
    .req_data(req_data), .req_ack(req_ack), .c1TxAlmFull(almf), .c1Tx_valid(tx_valid),
    .c1Tx_hdr(tx_hdr), .c1Tx_data(tx_data), .busy(busy), .err_proto(err)
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    , .c1Rx_rspValid(rx_v), .c1Rx_mdata(rx_md), .rsp_valid(rsp_valid)
`endif
  );

  typedef struct {
    logic           rst_n;
    logic           almf;
    logic [3:0]     vld;
    logic [3:0][7:0] ctl;
    logic [3:0]     ack;
    logic           txv;
    logic           busy;
    logic           err;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic a, input logic [3:0] vld,
                     input logic [7:0] c3, input logic [7:0] c2, input logic [7:0] c1,
                     input logic [7:0] c0, input logic [3:0] ack, input logic txv,
                     input logic bsy, input logic e);
    vec_t v;
    v.rst_n = r; v.almf = a; v.vld = vld;
    v.ctl[3] = c3; v.ctl[2] = c2; v.ctl[1] = c1; v.ctl[0] = c0;
    v.ack = ack; v.txv = txv; v.busy = bsy; v.err = e;
    vq.push_back(v);
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int r, input logic [7:0] c, input int idx);
    logic [HW-1:0] h;
    h = '0;
    h[71]    = c[7];
    h[69:68] = c[5:4];
    h[67:64] = c[3:0];
    h[57:16] = 42'(idx * 16 + r);
    h[15:0]  = {2'b00, 2'(r), 12'(idx)};
    return h;
  endfunction

  function automatic logic [511:0] mk_data(input int r, input int idx);
    return {8'(r), 472'(0), 8'(8'hA0 + r), 24'(idx)};
  endfunction

  function automatic logic [HW-1:0] exp_hdr(input int r, input logic [7:0] c, input int idx);
    logic [HW-1:0] h;
    h = mk_hdr(r, c, idx);
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    h[15:14] = 2'(r);
`endif
    return h;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    rst_n     = v.rst_n;
    almf      = v.almf;
    req_valid = v.vld;
    for (int r = 0; r < N; r++) begin
      req_hdr[r*HW +: HW]   = mk_hdr(r, v.ctl[r], idx);
      req_data[r*512 +: 512] = mk_data(r, idx);
    end
  endtask

  initial begin
    vec_t rv;
    int   pr;
    rv.rst_n = 1'b0; rv.almf = 1'b0; rv.vld = 4'hF;
    rv.ctl[3] = W1; rv.ctl[2] = W1; rv.ctl[1] = W1; rv.ctl[0] = W1;
    rv.ack = '0; rv.txv = 1'b0; rv.busy = 1'b0; rv.err = 1'b0;
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    rx_v = 1'b0; rx_md = '0;
`endif
    drive(rv, 999);

    // round robin 0..3 with single-beat writes
    add(1,0,4'hF, W1,W1,W1,W1, 4'b0001,0,0,0);
    add(1,0,4'hF, W1,W1,W1,W1, 4'b0010,1,0,0);
    add(1,0,4'hF, W1,W1,W1,W1, 4'b0100,1,0,0);
    add(1,0,4'hF, W1,W1,W1,W1, 4'b1000,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,0,0,0);
    add(1,0,4'b1001, W1,WC,WC,W1, 4'b0001,0,0,0);  // pointer wrapped back to 0
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);
    // 4-CL packet from req1 while req0/req2 wait
    add(1,0,4'b0111, WC,W1,W4,W1, 4'b0010,0,0,0);
    add(1,0,4'b0111, WC,W1,WC,W1, 4'b0010,1,1,0);
    add(1,0,4'b0111, WC,W1,WC,W1, 4'b0010,1,1,0);
    add(1,0,4'b0111, WC,W1,WC,W1, 4'b0010,1,1,0);
    add(1,0,4'b0101, WC,W1,WC,W1, 4'b0100,1,0,0);
    add(1,0,4'b0001, WC,WC,WC,W1, 4'b0001,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);
    // almost-full blocks arbitration
    for (int i = 0; i < 10; i++) add(1,1,4'hF, W1,W1,W1,W1, 4'b0000,0,0,0);
    // almost-full after beat 1 of a 2-CL packet
    add(1,0,4'b1110, W1,W1,W2,WC, 4'b0010,0,0,0);
    add(1,1,4'b1110, W1,W1,WC,WC, 4'b0010,1,1,0);
    add(1,1,4'b1110, W1,W1,WC,WC, 4'b0000,1,0,0);
    add(1,1,4'b1110, W1,W1,WC,WC, 4'b0000,0,0,0);
    add(1,0,4'b1110, W1,W1,WC,WC, 4'b0100,0,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);
    // sop repeated on beat 2 of a 2-CL packet
    add(1,0,4'b1000, W2,WC,WC,WC, 4'b1000,0,0,0);
    add(1,0,4'b1000, W2,WC,WC,WC, 4'b1000,1,1,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,1);
    add(0,0,4'h0, WC,WC,WC,WC, 4'b0000,0,0,1);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,0,0,0);
    // reserved cl_len is a single beat with error
    add(1,0,4'b0001, WC,WC,WC,WR, 4'b0001,0,0,0);
    add(1,0,4'b0011, WC,WC,W1,W1, 4'b0010,1,0,1);
    add(1,0,4'b0001, WC,WC,WC,W1, 4'b0001,1,0,1);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,1);
    // reset in the middle of a 4-CL packet
    add(1,0,4'b0010, WC,WC,W4,WC, 4'b0010,0,0,1);
    add(1,0,4'b0010, WC,WC,WC,WC, 4'b0010,1,1,1);
    add(0,0,4'b0010, WC,WC,WC,WC, 4'b0000,1,1,1);
    add(1,0,4'b1000, W1,WC,WC,WC, 4'b1000,0,0,0);
    add(1,0,4'b0011, WC,WC,W1,W1, 4'b0001,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,0,0,0);
    // fences are single-beat regardless of sop
    add(1,0,4'b0100, WC,FN,WC,WC, 4'b0100,0,0,0);
    add(1,0,4'b0100, WC,FN,WC,WC, 4'b0100,1,0,0);
    add(1,0,4'h0, WC,WC,WC,WC, 4'b0000,1,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 512'(req_ack), 512'(0));
    chk("rst_txv", 512'(tx_valid), 512'(0));
    chk("rst_hdr", 512'(tx_hdr), 512'(0));
    chk("rst_data", tx_data, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    chk("rst_rsp", 512'(rsp_valid), 512'(0));
`endif

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i], i);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i),  512'(req_ack),  512'(vq[i].ack));
      chk($sformatf("v%0d_txv", i),  512'(tx_valid), 512'(vq[i].txv));
      chk($sformatf("v%0d_busy", i), 512'(busy),     512'(vq[i].busy));
      chk($sformatf("v%0d_err", i),  512'(err),      512'(vq[i].err));
      if (vq[i].txv && i > 0) begin
        pr = 0;
        for (int r = 0; r < N; r++) if (vq[i-1].ack[r]) pr = r;
        chk($sformatf("v%0d_hdr", i),  512'(tx_hdr), 512'(exp_hdr(pr, vq[i-1].ctl[pr], i-1)));
        chk($sformatf("v%0d_data", i), tx_data, mk_data(pr, i-1));
      end
    end

`ifdef CCIP_C1_ARB_MDATA_TAG_EN
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_hdr[2*HW +: HW] = '0;
    req_hdr[2*HW + 71] = 1'b1;
    req_hdr[2*HW +: 16] = 16'h0005;
    @(negedge clk);
    chk("tag_ack", 512'(req_ack), 512'(4'b0100));
    @(posedge clk); #1;
    req_valid = '0; rx_v = 1'b1; rx_md = 16'h8005;
    @(negedge clk);
    chk("tag_mdata", 512'(tx_hdr[15:0]), 512'(16'h8005));
    @(posedge clk); #1;
    rx_v = 1'b0;
    @(negedge clk);
    chk("rsp_pulse", 512'(rsp_valid), 512'(4'b0100));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_clear", 512'(rsp_valid), 512'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
